// File: rtl/fmcw_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// fmcw_frame_ctrl_if
//   Handshake bundle between the FMCW frame sequencer and the processing chain.
//
//   Requests/status into the sequencer:
//     start, cont_mode, adf_done, window_valid, fft_done, xfer_empty
//   Enables/status out of the sequencer:
//     adf_en, fir_en, fifo_wren, fifo_rden, fft_en, busy,
//     chirp_idx[CHIRP_W], frame_done, timeout_err
//
//   slave  : the sequencer side (fmcw_frame_ctrl)
//   master : the environment side that issues requests and consumes enables
//   CHIRP_W must match the CHIRP_W of the attached fmcw_frame_ctrl.
// -----------------------------------------------------------------------------
interface fmcw_frame_ctrl_if #(
    parameter int CHIRP_W = 8
);
    logic               start;
    logic               cont_mode;
    logic               adf_done;
    logic               window_valid;
    logic               fft_done;
    logic               xfer_empty;

    logic               adf_en;
    logic               fir_en;
    logic               fifo_wren;
    logic               fifo_rden;
    logic               fft_en;
    logic               busy;
    logic [CHIRP_W-1:0] chirp_idx;
    logic               frame_done;
    logic               timeout_err;

    modport master (
        output start, cont_mode, adf_done, window_valid, fft_done, xfer_empty,
        input  adf_en, fir_en, fifo_wren, fifo_rden, fft_en, busy,
               chirp_idx, frame_done, timeout_err
    );

    modport slave (
        input  start, cont_mode, adf_done, window_valid, fft_done, xfer_empty,
        output adf_en, fir_en, fifo_wren, fifo_rden, fft_en, busy,
               chirp_idx, frame_done, timeout_err
    );
endinterface

// File: rtl/fmcw_frame_ctrl.sv
// -----------------------------------------------------------------------------
// fmcw_frame_ctrl
//   Frame sequencer for the FMCW radar chain. Each frame is N_CHIRPS chirps;
//   every chirp walks CFG (ADF ramp setup) -> ACQ (N_SAMPLES windowed writes
//   into the FIFO) -> FFT -> XFER (host drain). Frames run single-shot on
//   start, or back-to-back while cont_mode is high at frame end. A per-phase
//   watchdog returns to IDLE and raises a sticky timeout_err if a phase stalls.
//
//   Ports:
//     clk  : system clock
//     rst  : synchronous, active-high reset
//     bus  : fmcw_frame_ctrl_if.slave handshake bundle
//            in : start, cont_mode, adf_done, window_valid, fft_done, xfer_empty
//            out: adf_en, fir_en, fifo_wren, fifo_rden, fft_en, busy,
//                 chirp_idx, frame_done, timeout_err
//
//   Enables and busy are decoded from the state register; chirp_idx,
//   frame_done and timeout_err are registered.
// -----------------------------------------------------------------------------
module fmcw_frame_ctrl #(
    parameter int N_SAMPLES    = 1024,  // FIFO writes per chirp (>= 2)
    parameter int N_CHIRPS     = 1,     // chirps per frame (>= 1)
    parameter int CHIRP_W      = 8,     // chirp_idx width, 2**CHIRP_W >= N_CHIRPS
    parameter int FFT_EN_DELAY = 1,     // cycles fifo_rden leads fft_en (0..15)
    parameter int TIMEOUT      = 65535  // per-phase cycle limit, 0 = no watchdog
) (
    input  logic                clk,
    input  logic                rst,
    fmcw_frame_ctrl_if.slave    bus
);

    localparam int SAMP_W = $clog2(N_SAMPLES);
    localparam int DLY_W  = (FFT_EN_DELAY > 0) ? $clog2(FFT_EN_DELAY + 1) : 1;
    localparam int WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_EN  = (TIMEOUT > 0);

    localparam logic [SAMP_W-1:0]  LAST_SAMPLE = SAMP_W'(N_SAMPLES - 1);
    localparam logic [DLY_W-1:0]   FFT_DELAY   = DLY_W'(FFT_EN_DELAY);
    localparam logic [CHIRP_W-1:0] LAST_CHIRP  = CHIRP_W'(N_CHIRPS - 1);
    // Value held by the watchdog on the TIMEOUT-th cycle spent in one phase.
    localparam logic [WD_W-1:0]    WD_LAST     = WD_EN ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        ACQ,
        FFT,
        XFER
    } state_e;

    state_e             state_q,       state_d;
    logic [SAMP_W-1:0]  samp_q,        samp_d;
    logic [DLY_W-1:0]   dly_q,         dly_d;
    logic [WD_W-1:0]    wd_q,          wd_d;
    logic [CHIRP_W-1:0] chirp_q,       chirp_d;
    logic               frame_done_q,  frame_done_d;
    logic               timeout_err_q, timeout_err_d;

    logic adf_en;
    logic fir_en;
    logic fifo_wren;
    logic fifo_rden;
    logic fft_en;
    logic wd_trip;

    // Watchdog fires on the last permitted cycle of an active phase.
    assign wd_trip = WD_EN && (state_q != IDLE) && (wd_q == WD_LAST);

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement leaves one unassigned (no latch).
        state_d       = state_q;
        samp_d        = samp_q;
        dly_d         = dly_q;
        chirp_d       = chirp_q;
        wd_d          = wd_q;
        frame_done_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        adf_en        = 1'b0;
        fir_en        = 1'b0;
        fifo_wren     = 1'b0;
        fifo_rden     = 1'b0;
        fft_en        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // start is only honoured here, so a start while busy is a no-op.
                if (bus.start) begin
                    timeout_err_d = 1'b0;
                end
                if (bus.start || bus.cont_mode) begin
                    state_d = CFG;
                end
            end

            CFG: begin
                adf_en = 1'b1;
                if (bus.adf_done) begin
                    state_d = ACQ;
                    samp_d  = '0;
                end
            end

            ACQ: begin
                adf_en    = 1'b1;
                fir_en    = 1'b1;
                fifo_wren = bus.window_valid;
                if (bus.window_valid) begin
                    if (samp_q == LAST_SAMPLE) begin
                        // Last write of the chirp; the delay counter is primed
                        // here so the first FFT cycle sees zero.
                        state_d = FFT;
                        dly_d   = '0;
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end

            FFT: begin
                fifo_rden = 1'b1;
                fft_en    = (dly_q == FFT_DELAY);
                // Saturate at the programmed delay so fft_en holds until exit.
                if (dly_q != FFT_DELAY) begin
                    dly_d = dly_q + 1'b1;
                end
                if (bus.fft_done) begin
                    state_d = XFER;
                end
            end

            XFER: begin
                if (bus.xfer_empty) begin
                    if (chirp_q == LAST_CHIRP) begin
                        // Frame end is the only point cont_mode is looked at.
                        chirp_d      = '0;
                        frame_done_d = 1'b1;
                        state_d      = bus.cont_mode ? CFG : IDLE;
                    end else begin
                        chirp_d = chirp_q + 1'b1;
                        state_d = CFG;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The watchdog overrides any phase exit decided above.
        if (wd_trip) begin
            state_d       = IDLE;
            chirp_d       = '0;
            frame_done_d  = 1'b0;
            timeout_err_d = 1'b1;
        end

        // Per-phase cycle count: restarts on every state change.
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (WD_EN && (state_q != IDLE)) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample the values
        // from before this edge, independent of statement order.
        if (rst) begin
            state_q       <= IDLE;
            samp_q        <= '0;
            dly_q         <= '0;
            wd_q          <= '0;
            chirp_q       <= '0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            samp_q        <= samp_d;
            dly_q         <= dly_d;
            wd_q          <= wd_d;
            chirp_q       <= chirp_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.adf_en      = adf_en;
    assign bus.fir_en      = fir_en;
    assign bus.fifo_wren   = fifo_wren;
    assign bus.fifo_rden   = fifo_rden;
    assign bus.fft_en      = fft_en;
    assign bus.busy        = (state_q != IDLE);
    assign bus.chirp_idx   = chirp_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fmcw_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fmcw_frame_ctrl
//   Three sequencer instances with different parameter sets share one clock:
//     dut0: N_SAMPLES=8, N_CHIRPS=1, FFT_EN_DELAY=1, watchdog off
//     dut1: N_SAMPLES=8, N_CHIRPS=3, FFT_EN_DELAY=3, TIMEOUT=200
//     dut2: N_SAMPLES=8, N_CHIRPS=1, FFT_EN_DELAY=0, TIMEOUT=16
//   Inputs change 1 time unit after the rising edge; outputs are compared on
//   the falling edge against a phase/count model of the frame rules, and a set
//   of hand-derived expectations pins specific cycles and event counts.
// -----------------------------------------------------------------------------
module tb_fmcw_frame_ctrl;

    localparam int NI = 3;
    localparam int P_NS [NI] = '{8, 8, 8};
    localparam int P_NC [NI] = '{1, 3, 1};
    localparam int P_D  [NI] = '{1, 3, 0};
    localparam int P_TO [NI] = '{0, 200, 16};

    typedef enum int {PH_IDLE, PH_CFG, PH_ACQ, PH_FFT, PH_XFER} phase_e;

    typedef struct packed {
        logic       adf_en;
        logic       fir_en;
        logic       fifo_wren;
        logic       fifo_rden;
        logic       fft_en;
        logic       busy;
        logic       frame_done;
        logic       timeout_err;
        logic [7:0] chirp_idx;
    } outs_t;

    // Model of one instance: current phase and how long it has lasted.
    typedef struct {
        phase_e phase;
        int     writes;     // FIFO writes done in this chirp
        int     in_phase;   // cycles already spent in the current phase
        int     chirp;
        bit     done;
        bit     terr;
        bit     valid;      // model has seen reset
    } model_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_v   [NI];
    logic start_v [NI];
    logic cont_v  [NI];
    logic adf_v   [NI];
    logic wv_v    [NI];
    logic fftd_v  [NI];
    logic xe_v    [NI];
    outs_t act    [NI];

    model_t m [NI];
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int wren_cnt   [NI];
    int done_cnt   [NI];
    int fften_cnt  [NI];
    int rden_rise  [NI];
    int fften_rise [NI];
    bit rden_prev  [NI];
    bit fften_prev [NI];

    fmcw_frame_ctrl_if #(.CHIRP_W(8)) bus0 ();
    fmcw_frame_ctrl_if #(.CHIRP_W(8)) bus1 ();
    fmcw_frame_ctrl_if #(.CHIRP_W(8)) bus2 ();

    assign bus0.start = start_v[0]; assign bus0.cont_mode = cont_v[0];
    assign bus0.adf_done = adf_v[0]; assign bus0.window_valid = wv_v[0];
    assign bus0.fft_done = fftd_v[0]; assign bus0.xfer_empty = xe_v[0];
    assign bus1.start = start_v[1]; assign bus1.cont_mode = cont_v[1];
    assign bus1.adf_done = adf_v[1]; assign bus1.window_valid = wv_v[1];
    assign bus1.fft_done = fftd_v[1]; assign bus1.xfer_empty = xe_v[1];
    assign bus2.start = start_v[2]; assign bus2.cont_mode = cont_v[2];
    assign bus2.adf_done = adf_v[2]; assign bus2.window_valid = wv_v[2];
    assign bus2.fft_done = fftd_v[2]; assign bus2.xfer_empty = xe_v[2];

    assign act[0] = {bus0.adf_en, bus0.fir_en, bus0.fifo_wren, bus0.fifo_rden, bus0.fft_en,
                     bus0.busy, bus0.frame_done, bus0.timeout_err, bus0.chirp_idx};
    assign act[1] = {bus1.adf_en, bus1.fir_en, bus1.fifo_wren, bus1.fifo_rden, bus1.fft_en,
                     bus1.busy, bus1.frame_done, bus1.timeout_err, bus1.chirp_idx};
    assign act[2] = {bus2.adf_en, bus2.fir_en, bus2.fifo_wren, bus2.fifo_rden, bus2.fft_en,
                     bus2.busy, bus2.frame_done, bus2.timeout_err, bus2.chirp_idx};

    fmcw_frame_ctrl #(.N_SAMPLES(P_NS[0]), .N_CHIRPS(P_NC[0]), .CHIRP_W(8),
                      .FFT_EN_DELAY(P_D[0]), .TIMEOUT(P_TO[0]))
        dut0 (.clk(clk), .rst(rst_v[0]), .bus(bus0));
    fmcw_frame_ctrl #(.N_SAMPLES(P_NS[1]), .N_CHIRPS(P_NC[1]), .CHIRP_W(8),
                      .FFT_EN_DELAY(P_D[1]), .TIMEOUT(P_TO[1]))
        dut1 (.clk(clk), .rst(rst_v[1]), .bus(bus1));
    fmcw_frame_ctrl #(.N_SAMPLES(P_NS[2]), .N_CHIRPS(P_NC[2]), .CHIRP_W(8),
                      .FFT_EN_DELAY(P_D[2]), .TIMEOUT(P_TO[2]))
        dut2 (.clk(clk), .rst(rst_v[2]), .bus(bus2));

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // What the outputs must be this cycle, from the phase the model is in.
    function automatic outs_t expect_outs(input int k);
        outs_t o;
        o             = '0;
        o.adf_en      = (m[k].phase == PH_CFG) || (m[k].phase == PH_ACQ);
        o.fir_en      = (m[k].phase == PH_ACQ);
        o.fifo_wren   = (m[k].phase == PH_ACQ) && wv_v[k];
        o.fifo_rden   = (m[k].phase == PH_FFT);
        o.fft_en      = (m[k].phase == PH_FFT) && (m[k].in_phase >= P_D[k]);
        o.busy        = (m[k].phase != PH_IDLE);
        o.frame_done  = m[k].done;
        o.timeout_err = m[k].terr;
        o.chirp_idx   = 8'(m[k].chirp);
        return o;
    endfunction

    // Advance the model across the coming clock edge using this cycle's inputs.
    task automatic model_step(input int k);
        phase_e nxt;
        bit     done;
        if (rst_v[k]) begin
            m[k].phase    = PH_IDLE;
            m[k].writes   = 0;
            m[k].in_phase = 0;
            m[k].chirp    = 0;
            m[k].done     = 1'b0;
            m[k].terr     = 1'b0;
            m[k].valid    = 1'b1;
            return;
        end
        if (!m[k].valid) return;
        nxt  = m[k].phase;
        done = 1'b0;
        if (P_TO[k] > 0 && m[k].phase != PH_IDLE && m[k].in_phase + 1 >= P_TO[k]) begin
            nxt        = PH_IDLE;
            m[k].terr  = 1'b1;
            m[k].chirp = 0;
        end else begin
            case (m[k].phase)
                PH_IDLE: begin
                    if (start_v[k]) m[k].terr = 1'b0;
                    if (start_v[k] || cont_v[k]) nxt = PH_CFG;
                end
                PH_CFG: begin
                    if (adf_v[k]) begin
                        nxt         = PH_ACQ;
                        m[k].writes = 0;
                    end
                end
                PH_ACQ: begin
                    if (wv_v[k]) begin
                        m[k].writes++;
                        if (m[k].writes == P_NS[k]) nxt = PH_FFT;
                    end
                end
                PH_FFT: begin
                    if (fftd_v[k]) nxt = PH_XFER;
                end
                default: begin
                    if (xe_v[k]) begin
                        if (m[k].chirp + 1 < P_NC[k]) begin
                            m[k].chirp++;
                            nxt = PH_CFG;
                        end else begin
                            m[k].chirp = 0;
                            done       = 1'b1;
                            nxt        = cont_v[k] ? PH_CFG : PH_IDLE;
                        end
                    end
                end
            endcase
        end
        m[k].done = done;
        if (nxt != m[k].phase) m[k].in_phase = 0;
        else if (m[k].phase != PH_IDLE) m[k].in_phase++;
        m[k].phase = nxt;
    endtask

    // One clock cycle: compare on the falling edge, then let the edge happen.
    task automatic tick(input int n = 1);
        outs_t e;
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (m[k].valid) begin
                    e = expect_outs(k);
                    n_checks++;
                    if (act[k] !== e) begin
                        n_errors++;
                        $display("FAIL dut%0d outputs cycle %0d: got %h expected %h (adf,fir,wren,rden,fft,busy,done,terr|chirp)",
                                 k, cyc, act[k], e);
                    end
                end
                if (act[k].fifo_wren === 1'b1) wren_cnt[k]++;
                if (act[k].frame_done === 1'b1) done_cnt[k]++;
                if (act[k].fft_en === 1'b1) fften_cnt[k]++;
                if (act[k].fifo_rden === 1'b1 && !rden_prev[k]) rden_rise[k] = cyc;
                if (act[k].fft_en === 1'b1 && !fften_prev[k]) fften_rise[k] = cyc;
                rden_prev[k]  = (act[k].fifo_rden === 1'b1);
                fften_prev[k] = (act[k].fft_en === 1'b1);
                model_step(k);
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    // Starts on the first CFG cycle of a chirp, ends on the cycle after xfer_empty.
    task automatic run_chirp(input int k, input int fft_cycles);
        tick(1);
        adf_v[k] = 1'b1; tick(1); adf_v[k] = 1'b0;
        wv_v[k] = 1'b1; tick(8); wv_v[k] = 1'b0;
        if (fft_cycles > 1) tick(fft_cycles - 1);
        fftd_v[k] = 1'b1; tick(1); fftd_v[k] = 1'b0;
        xe_v[k] = 1'b1; tick(1); xe_v[k] = 1'b0;
    endtask

    int w0, d0, f0;

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst_v[k] = 1'b1; start_v[k] = 1'b0; cont_v[k] = 1'b0; adf_v[k] = 1'b0;
            wv_v[k] = 1'b0; fftd_v[k] = 1'b0; xe_v[k] = 1'b0;
        end
        tick(2);
        for (int k = 0; k < NI; k++) rst_v[k] = 1'b0;
        tick(1);
        for (int k = 0; k < NI; k++) check($sformatf("dut%0d reset outputs", k), int'(act[k]), 0);

        // ---- single chirp, sparse window_valid --------------------------------
        w0 = wren_cnt[0]; d0 = done_cnt[0];
        start_v[0] = 1'b1; tick(1); start_v[0] = 1'b0;
        check("t1 busy after start", int'(act[0].busy), 1);
        tick(2);
        adf_v[0] = 1'b1; tick(1); adf_v[0] = 1'b0;
        check("t1 fir_en in acq", int'(act[0].fir_en), 1);
        for (int i = 0; i < 20; i++) begin
            wv_v[0] = (i % 2 == 1);
            tick(1);
        end
        wv_v[0] = 1'b0;
        check("t1 wren pulses", wren_cnt[0] - w0, 8);
        check("t1 rden lead over fft_en", fften_rise[0] - rden_rise[0], 1);
        fftd_v[0] = 1'b1; tick(1); fftd_v[0] = 1'b0;
        tick(2);
        xe_v[0] = 1'b1; tick(1); xe_v[0] = 1'b0;
        check("t1 frame_done", int'(act[0].frame_done), 1);
        check("t1 busy at frame end", int'(act[0].busy), 0);
        tick(2);
        check("t1 frame_done pulses", done_cnt[0] - d0, 1);

        // ---- reset in the middle of acquisition -------------------------------
        w0 = wren_cnt[0]; d0 = done_cnt[0];
        start_v[0] = 1'b1; tick(1); start_v[0] = 1'b0;
        adf_v[0] = 1'b1; tick(1); adf_v[0] = 1'b0;
        wv_v[0] = 1'b1; tick(4);
        rst_v[0] = 1'b1; wv_v[0] = 1'b0; tick(1); rst_v[0] = 1'b0;
        check("t2 outputs after rst", int'(act[0]), 0);
        check("t2 writes before rst", wren_cnt[0] - w0, 4);
        tick(3);
        check("t2 no frame_done on abort", done_cnt[0] - d0, 0);
        w0 = wren_cnt[0];
        start_v[0] = 1'b1; tick(1); start_v[0] = 1'b0;
        adf_v[0] = 1'b1; tick(1); adf_v[0] = 1'b0;
        wv_v[0] = 1'b1; tick(12); wv_v[0] = 1'b0;
        check("t2 full chirp writes", wren_cnt[0] - w0, 8);
        fftd_v[0] = 1'b1; tick(1); fftd_v[0] = 1'b0;
        xe_v[0] = 1'b1; tick(1); xe_v[0] = 1'b0;
        tick(1);
        check("t2 frame_done after rerun", done_cnt[0] - d0, 1);

        // ---- three chirps, single shot, fft_done on first FFT cycle -----------
        d0 = done_cnt[1]; f0 = fften_cnt[1];
        start_v[1] = 1'b1; tick(1); start_v[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t3 chirp%0d idx", c), int'(act[1].chirp_idx), c);
            check($sformatf("t3 chirp%0d in cfg", c), int'({act[1].adf_en, act[1].fir_en}), 2);
            run_chirp(1, 1);
        end
        check("t3 frame_done", int'(act[1].frame_done), 1);
        check("t3 idle at frame end", int'(act[1].busy), 0);
        check("t3 chirp_idx back to 0", int'(act[1].chirp_idx), 0);
        tick(1);
        check("t3 frame_done one cycle", int'(act[1].frame_done), 0);
        check("t3 frame_done pulses", done_cnt[1] - d0, 1);
        check("t3 fft_en cycles with delay 3", fften_cnt[1] - f0, 0);

        // ---- continuous mode, dropped during chirp 1 of frame 2 ---------------
        d0 = done_cnt[1]; f0 = fften_cnt[1];
        cont_v[1] = 1'b1; tick(1);
        for (int c = 0; c < 3; c++) run_chirp(1, 6);
        check("t4 frame_done with restart", int'({act[1].frame_done, act[1].adf_en}), 3);
        check("t4 restart chirp_idx", int'(act[1].chirp_idx), 0);
        run_chirp(1, 6);
        cont_v[1] = 1'b0;
        run_chirp(1, 6);
        run_chirp(1, 6);
        check("t4 last frame_done", int'(act[1].frame_done), 1);
        tick(2);
        check("t4 idle after cont drop", int'(act[1].busy), 0);
        check("t4 frame_done pulses", done_cnt[1] - d0, 2);
        check("t4 fft_en cycles", fften_cnt[1] - f0, 18);

        // ---- watchdog in CFG --------------------------------------------------
        d0 = done_cnt[2];
        start_v[2] = 1'b1; tick(1); start_v[2] = 1'b0;
        tick(15);
        check("t5 busy on 16th cfg cycle", int'({act[2].busy, act[2].timeout_err}), 2);
        tick(1);
        check("t5 timeout state", int'({act[2].busy, act[2].timeout_err}), 1);
        check("t5 no frame_done", int'(act[2].frame_done), 0);
        tick(3);
        check("t5 timeout_err sticky", int'(act[2].timeout_err), 1);
        check("t5 no frame_done count", done_cnt[2] - d0, 0);
        start_v[2] = 1'b1; tick(1); start_v[2] = 1'b0;
        check("t5 start clears err", int'({act[2].busy, act[2].timeout_err}), 2);

        // ---- zero FFT delay, fft_done on first FFT cycle -----------------------
        f0 = fften_cnt[2];
        run_chirp(2, 1);
        check("t6 fft_en cycles with delay 0", fften_cnt[2] - f0, 1);
        check("t6 frame_done", int'(act[2].frame_done), 1);

        // ---- timeout and phase exit in the same cycle -------------------------
        start_v[2] = 1'b1; tick(1); start_v[2] = 1'b0;
        tick(15);
        adf_v[2] = 1'b1; tick(1); adf_v[2] = 1'b0;
        check("t7 timeout beats adf_done", int'({act[2].busy, act[2].timeout_err}), 1);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fmcw_frame_ctrl.md
Name: fmcw_frame_ctrl

Overview:
Top-level sequencer for the FMCW radar processing chain. It drives a multi-chirp frame through four phases: ADF ramp configuration, FIR/window sample acquisition into the FIFO, FFT, and host transfer. It generalises the single-chirp controller with the following additions:
- a configurable sample count and chirps per frame;
- a programmable FFT start delay;
- single-shot and continuous modes;
- a watchdog that aborts stalled phases.

Parameters:
N_SAMPLES, 1024, windowed samples written to FIFO per chirp (>=2)
N_CHIRPS, 1, chirps per frame (>=1)
CHIRP_W, 8, width of chirp_idx (2**CHIRP_W >= N_CHIRPS)
FFT_EN_DELAY, 1, cycles fifo_rden leads fft_en in FFT phase (0..15)
TIMEOUT, 65535, watchdog limit in cycles per phase; 0 disables watchdog

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to run one frame
cont_mode  in  1  1 = restart frames back-to-back
adf_done  in  1  ADF ramp configuration complete
window_valid  in  1  window output sample valid
fft_done  in  1  FFT finished
xfer_empty  in  1  host transfer buffer drained
adf_en  out  1  ADF enable
fir_en  out  1  FIR enable
fifo_wren  out  1  FIFO write enable
fifo_rden  out  1  FIFO read enable
fft_en  out  1  FFT enable
busy  out  1  high in any state other than IDLE
chirp_idx  out  CHIRP_W  index of the current chirp within the frame
frame_done  out  1  one-cycle pulse at frame end
timeout_err  out  1  sticky watchdog error flag

Behaviour:
- Reset: state=IDLE; sample, delay, watchdog and chirp counters = 0; all outputs 0. A reset asserted mid-frame aborts the frame with no frame_done pulse.
- States: IDLE, CFG, ACQ, FFT, XFER. Enables are decoded combinationally from state. frame_done and timeout_err are registered.
- IDLE:
  - All enables 0.
  - Go to CFG when start=1 or cont_mode=1.
  - start also clears timeout_err.
  - start while busy is ignored.
- CFG:
  - adf_en=1.
  - On adf_done, go to ACQ and clear the sample counter.
- ACQ:
  - adf_en=1, fir_en=1, fifo_wren=window_valid in the same cycle.
  - Each window_valid increments the sample counter.
  - A window_valid with count==N_SAMPLES-1 moves to FFT, so exactly N_SAMPLES writes occur per chirp.
  - Samples arriving after that point are dropped (no wren).
- FFT:
  - fifo_rden=1 from the first FFT cycle.
  - fft_en=1 once the delay counter reaches FFT_EN_DELAY, and stays high until exit. With FFT_EN_DELAY=0, fft_en=1 on the first cycle.
  - fft_done moves to XFER regardless of the delay count.
- XFER:
  - All enables 0.
  - On xfer_empty with chirp_idx<N_CHIRPS-1: chirp_idx+1, go to CFG.
  - On xfer_empty with chirp_idx==N_CHIRPS-1: chirp_idx<=0 and frame_done=1 for exactly one cycle. Then go to CFG if cont_mode=1, else go to IDLE.
  - cont_mode is sampled only at frame end, so deasserting it mid-frame finishes the current frame.
- Watchdog (TIMEOUT>0):
  - The counter clears on every state change and increments every cycle in CFG, ACQ, FFT and XFER.
  - When it reaches TIMEOUT in any of those states, it forces IDLE, sets timeout_err=1, clears chirp_idx, and gives no frame_done.
  - If the timeout and the phase-exit event occur in the same cycle, the timeout wins.
  - timeout_err clears only on rst or on start in IDLE.
- Counter widths are derived with $clog2. No counter may wrap within a legal phase.

Test Plan:
- rst, then start, N_CHIRPS=1, N_SAMPLES=8, adf_done after 3 cycles, window_valid every other cycle:
  - exactly 8 fifo_wren pulses;
  - fifo_rden precedes fft_en by 1 cycle;
  - after fft_done then xfer_empty, frame_done pulses once, busy=0, state returns to IDLE.
- N_CHIRPS=3, single shot: chirp_idx steps 0,1,2 with CFG revisited before each chirp; one frame_done after chirp 2; chirp_idx returns to 0.
- cont_mode=1: the second frame's CFG (adf_en=1) starts the cycle after frame_done. Drop cont_mode during chirp 1 → that frame completes, then IDLE.
- TIMEOUT=16, adf_done never asserted: timeout_err=1 and busy=0 at cycle 16 of CFG with no frame_done. A subsequent start clears timeout_err.
- Assert rst mid-ACQ after 4 writes: all outputs 0 next cycle. The next frame writes a full 8 samples.
- FFT_EN_DELAY=0 and 3, with fft_done arriving at FFT cycle 1: fft_en is high for 1 and 0 cycles respectively; the FSM still transitions to XFER.
